// File: rtl/lsu_mem_port_if.sv
// Word-wide valid/ready memory bus between the load/store unit and data memory.
// The command phase uses mem_valid/mem_ready; read data returns later on mem_rvalid.
interface lsu_mem_port_if #(
  parameter int AW = 32
);
  logic          mem_valid;
  logic          mem_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdata;
  logic          mem_rvalid;
  logic [31:0]   mem_rdata;

  modport master (
    output mem_valid, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu_mem_port.sv
// Load/store unit memory port: one request at a time, misaligned accesses split
// into two word beats, load data reassembled and sign/zero-extended.
module lsu_mem_port #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  output logic [DW-1:0] resp_rdata,
  lsu_mem_port_if.master mem,
  output logic          busy
);

  typedef enum logic [2:0] {IDLE, CMD0, RD0, CMD1, RD1, DONE} state_t;

  state_t        state, state_n;
  logic          we_q;
  logic [1:0]    size_q;
  logic          uns_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   lo_q, hi_q;

  logic [1:0]    off;
  logic [3:0]    mask;
  logic [7:0]    be_wide;
  logic [63:0]   wd_wide;
  logic          split;
  logic [AW-1:0] base;
  logic [31:0]   lo_n, hi_n, raw;

  function automatic logic [31:0] extend_load(input logic [31:0] r, input logic [1:0] size,
                                              input logic uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] s;
    b = r[7:0];
    h = r[15:0];
    case (size)
      2'b00: begin
        s = b;
        extend_load = uns ? {24'b0, r[7:0]} : s;
      end
      2'b01: begin
        s = h;
        extend_load = uns ? {16'b0, r[15:0]} : s;
      end
      default: extend_load = r;
    endcase
  endfunction

  assign off  = addr_q[1:0];
  assign mask = (size_q == 2'b00) ? 4'b0001 : (size_q == 2'b01) ? 4'b0011 : 4'b1111;
  assign split = ((size_q == 2'b01) && (off == 2'b11)) || (size_q[1] && (off != 2'b00));
  assign base = {addr_q[AW-1:2], 2'b00};

  // Upper halves of the shifted lane vectors are exactly the beat-1 byte enables and data.
  assign be_wide = {4'b0000, mask} << off;
  assign wd_wide = {32'b0, wdata_q} << {off, 3'b000};

  assign lo_n = (state == RD0) ? mem.mem_rdata : lo_q;
  assign hi_n = (state == RD1) ? mem.mem_rdata : hi_q;
  assign raw  = 32'({(split ? hi_n : 32'b0), lo_n} >> {off, 3'b000});

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == DONE);
  assign busy       = (state != IDLE);

  always_comb begin
    state_n       = state;
    mem.mem_valid = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = base;
    mem.mem_be    = 4'b0000;
    mem.mem_wdata = wd_wide[31:0];
    case (state)
      IDLE: if (req_valid) state_n = CMD0;
      CMD0: begin
        mem.mem_valid = 1'b1;
        mem.mem_we    = we_q;
        mem.mem_be    = be_wide[3:0];
        if (mem.mem_ready) state_n = !we_q ? RD0 : (split ? CMD1 : DONE);
      end
      RD0: if (mem.mem_rvalid) state_n = split ? CMD1 : DONE;
      CMD1: begin
        mem.mem_valid = 1'b1;
        mem.mem_we    = we_q;
        mem.mem_addr  = base + AW'(4);
        mem.mem_be    = be_wide[7:4];
        mem.mem_wdata = wd_wide[63:32];
        if (mem.mem_ready) state_n = we_q ? DONE : RD1;
      end
      RD1: if (mem.mem_rvalid) state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      resp_rdata <= '0;
    end else begin
      state <= state_n;
      if ((state != DONE) && (state_n == DONE))
        resp_rdata <= we_q ? '0 : extend_load(raw, size_q, uns_q);
    end
  end

  // Request fields and captured read words carry no reset; they are only used once qualified.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && req_valid) begin
      we_q    <= req_we;
      size_q  <= req_size;
      uns_q   <= req_unsigned;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
    if ((state == RD0) && mem.mem_rvalid) lo_q <= mem.mem_rdata;
    if ((state == RD1) && mem.mem_rvalid) hi_q <= mem.mem_rdata;
  end

endmodule
